// File: rtl/riu_pkg.sv
// Shared definitions for the RIU access blocks: FSM state encodings,
// nibble-select codes and small decode helpers.
package riu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_VALID = 3'd1,
        ST_SELECT     = 3'd2,
        ST_RD_WAIT    = 3'd3,
        ST_DONE       = 3'd4,
        ST_ERR        = 3'd5
    } riu_state_e;

    localparam logic [1:0] NIB_SEL_NONE = 2'b00;
    localparam logic [1:0] NIB_SEL_LO   = 2'b01;
    localparam logic [1:0] NIB_SEL_HI   = 2'b10;

    function automatic logic [1:0] nib_code(input logic nib);
        if (nib) begin
            return NIB_SEL_HI;
        end else begin
            return NIB_SEL_LO;
        end
    endfunction

    function automatic logic [3:0] bg_onehot(input logic [1:0] bg);
        case (bg)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            2'd3:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/riu_rr_arb.sv
// Two-way round-robin arbiter: combinational grant from the current
// favoured requester, pointer moves away from whoever was granted.
module riu_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic prio_r;

    // Grant selection: a lone request wins, a tie goes to the favoured side.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_r ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Priority pointer: after a grant, favour the other requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= 1'b0;
        end else if (update && (grant != 2'b00)) begin
            prio_r <= ~grant[1];
        end else begin
            prio_r <= prio_r;
        end
    end

endmodule

// File: rtl/riu_arbiter.sv
// Arbitrates two requesters onto one RIU port: waits for byte-group valid,
// drives the nibble select / write strobe, and returns read data or a timeout.
module riu_arbiter
    import riu_pkg::*;
#(
    parameter int RD_LAT    = 2,
    parameter int VALID_TMO = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_we,
    input  logic [3:0]  req_bg,
    input  logic [1:0]  req_nib,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [1:0]  req_ack,
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    input  logic [3:0]  riu_valid_i,
    input  logic [15:0] riu_rd_data_bg0,
    input  logic [15:0] riu_rd_data_bg1,
    input  logic [15:0] riu_rd_data_bg2,
    input  logic [15:0] riu_rd_data_bg3,
    output logic [5:0]  riu_addr,
    output logic [1:0]  riu_nib_sel,
    output logic [15:0] riu_wr_data,
    output logic [3:0]  riu_wr_en,
    output logic        busy
);

    localparam logic [7:0] TMO_LAST = 8'(VALID_TMO - 1);
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    riu_state_e  state_r;
    logic        gnt_id_r;
    logic        we_r;
    logic [1:0]  bg_r;
    logic        nib_r;
    logic [15:0] wdata_r;
    logic [7:0]  tmo_cnt_r;
    logic [2:0]  lat_cnt_r;

    logic [1:0]  gnt_s;
    logic        gnt_idx_s;
    logic        arb_update_s;
    logic        we_s;
    logic [1:0]  bg_s;
    logic        nib_s;
    logic [5:0]  addr_s;
    logic [15:0] wdata_s;
    logic [15:0] rd_data_s;
    logic [1:0]  gnt_oh_s;

    assign arb_update_s = (state_r == ST_IDLE) && (req_valid != 2'b00);
    assign gnt_idx_s    = gnt_s[1];
    assign gnt_oh_s     = gnt_id_r ? 2'b10 : 2'b01;

    riu_rr_arb u_rr_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .update (arb_update_s),
        .grant  (gnt_s)
    );

    // Pick out the winning requester's fields for latching.
    always_comb begin
        if (gnt_idx_s) begin
            we_s    = req_we[1];
            bg_s    = req_bg[3:2];
            nib_s   = req_nib[1];
            addr_s  = req_addr[11:6];
            wdata_s = req_wdata[31:16];
        end else begin
            we_s    = req_we[0];
            bg_s    = req_bg[1:0];
            nib_s   = req_nib[0];
            addr_s  = req_addr[5:0];
            wdata_s = req_wdata[15:0];
        end
    end

    // Read-data source for the latched byte group.
    always_comb begin
        case (bg_r)
            2'd0:    rd_data_s = riu_rd_data_bg0;
            2'd1:    rd_data_s = riu_rd_data_bg1;
            2'd2:    rd_data_s = riu_rd_data_bg2;
            2'd3:    rd_data_s = riu_rd_data_bg3;
            default: rd_data_s = 16'h0000;
        endcase
    end

    // Transaction FSM; every output is set on entry to the state that shows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            gnt_id_r    <= 1'b0;
            we_r        <= 1'b0;
            bg_r        <= 2'd0;
            nib_r       <= 1'b0;
            wdata_r     <= 16'h0000;
            tmo_cnt_r   <= 8'd0;
            lat_cnt_r   <= 3'd0;
            req_ack     <= 2'b00;
            rsp_valid   <= 2'b00;
            rsp_rdata   <= 16'h0000;
            rsp_err     <= 1'b0;
            riu_addr    <= 6'd0;
            riu_nib_sel <= NIB_SEL_NONE;
            riu_wr_data <= 16'h0000;
            riu_wr_en   <= 4'b0000;
            busy        <= 1'b0;
        end else begin
            req_ack <= 2'b00;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid != 2'b00) begin
                        req_ack   <= gnt_s;
                        gnt_id_r  <= gnt_idx_s;
                        we_r      <= we_s;
                        bg_r      <= bg_s;
                        nib_r     <= nib_s;
                        wdata_r   <= wdata_s;
                        riu_addr  <= addr_s;
                        tmo_cnt_r <= 8'd0;
                        busy      <= 1'b1;
                        state_r   <= ST_WAIT_VALID;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_WAIT_VALID: begin
                    if (riu_valid_i[bg_r]) begin
                        riu_nib_sel <= nib_code(nib_r);
                        if (we_r) begin
                            riu_wr_en   <= bg_onehot(bg_r);
                            riu_wr_data <= wdata_r;
                        end else begin
                            riu_wr_en <= 4'b0000;
                        end
                        tmo_cnt_r <= 8'd0;
                        state_r   <= ST_SELECT;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        rsp_valid <= gnt_oh_s;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 16'h0000;
                        tmo_cnt_r <= 8'd0;
                        state_r   <= ST_ERR;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                ST_SELECT: begin
                    riu_wr_en   <= 4'b0000;
                    riu_wr_data <= 16'h0000;
                    if (we_r) begin
                        riu_nib_sel <= NIB_SEL_NONE;
                        rsp_valid   <= gnt_oh_s;
                        rsp_err     <= 1'b0;
                        rsp_rdata   <= 16'h0000;
                        state_r     <= ST_DONE;
                    end else begin
                        lat_cnt_r <= 3'd0;
                        state_r   <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (lat_cnt_r == LAT_LAST) begin
                        riu_nib_sel <= NIB_SEL_NONE;
                        rsp_valid   <= gnt_oh_s;
                        rsp_err     <= 1'b0;
                        rsp_rdata   <= rd_data_s;
                        lat_cnt_r   <= 3'd0;
                        state_r     <= ST_DONE;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + 3'd1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    rsp_valid <= 2'b00;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 16'h0000;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    rsp_valid   <= 2'b00;
                    rsp_err     <= 1'b0;
                    rsp_rdata   <= 16'h0000;
                    riu_nib_sel <= NIB_SEL_NONE;
                    riu_wr_en   <= 4'b0000;
                    busy        <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riu_arbiter.sv
// Self-checking bench for riu_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_riu_arbiter;

    localparam int RD_LAT    = 2;
    localparam int VALID_TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [3:0]  req_bg;
    logic [1:0]  req_nib;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_ack;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  riu_valid_i;
    logic [15:0] rdv [4];
    logic [5:0]  riu_addr;
    logic [1:0]  riu_nib_sel;
    logic [15:0] riu_wr_data;
    logic [3:0]  riu_wr_en;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    riu_arbiter #(.RD_LAT(RD_LAT), .VALID_TMO(VALID_TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_we          (req_we),
        .req_bg          (req_bg),
        .req_nib         (req_nib),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ack         (req_ack),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .riu_valid_i     (riu_valid_i),
        .riu_rd_data_bg0 (rdv[0]),
        .riu_rd_data_bg1 (rdv[1]),
        .riu_rd_data_bg2 (rdv[2]),
        .riu_rd_data_bg3 (rdv[3]),
        .riu_addr        (riu_addr),
        .riu_nib_sel     (riu_nib_sel),
        .riu_wr_data     (riu_wr_data),
        .riu_wr_en       (riu_wr_en),
        .busy            (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic we, input logic [1:0] bg, input logic nib,
                           input logic [5:0] addr, input logic [15:0] wd);
        req_we[r]            = we;
        req_bg[r*2 +: 2]     = bg;
        req_nib[r]           = nib;
        req_addr[r*6 +: 6]   = addr;
        req_wdata[r*16 +: 16] = wd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Observations of one single-requester transaction.
    logic [1:0]  o_ack, o_nib, o_rsp;
    logic [3:0]  o_wren;
    logic [15:0] o_wdata, o_rdata;
    logic        o_err, o_to;
    logic [5:0]  o_addr;
    int          o_nib_cnt, o_lat;

    task automatic do_txn(input int r);
        int  cyc;
        bit  got_ack;
        bit  got_rsp;
        o_ack = 2'b00; o_nib = 2'b00; o_rsp = 2'b00; o_wren = 4'b0000;
        o_wdata = 16'h0000; o_rdata = 16'h0000; o_err = 1'b0; o_to = 1'b0;
        o_addr = 6'd0; o_nib_cnt = 0; o_lat = -1;
        @(negedge clk);
        req_valid[r] = 1'b1;
        got_ack = 1'b0;
        cyc = 0;
        while (!got_ack && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (req_ack != 2'b00) begin
                got_ack = 1'b1;
                o_ack   = req_ack;
            end
        end
        req_valid[r] = 1'b0;
        if (!got_ack) begin
            o_to = 1'b1;
            return;
        end
        cyc = 0;
        got_rsp = 1'b0;
        while (!got_rsp && cyc < 600) begin
            if (riu_nib_sel != 2'b00) begin
                o_nib = riu_nib_sel;
                o_nib_cnt++;
            end
            if (riu_wr_en != 4'b0000) begin
                o_wren  = riu_wr_en;
                o_wdata = riu_wr_data;
            end
            if (rsp_valid != 2'b00) begin
                got_rsp = 1'b1;
                o_rsp   = rsp_valid;
                o_rdata = rsp_rdata;
                o_err   = rsp_err;
                o_addr  = riu_addr;
                o_lat   = cyc;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!got_rsp) o_to = 1'b1;
    endtask

    typedef struct {
        int          r;
        logic        we;
        logic [1:0]  bg;
        logic        nib;
        logic [5:0]  addr;
        logic [15:0] wd;
        logic [15:0] rd;
        logic [1:0]  e_ack;
        logic [1:0]  e_nib;
        int          e_nib_cnt;
        logic [3:0]  e_wren;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [1:0]  pend;
        logic        mptr;
        int          cur;
        int          nibcnt;
        int          got[4];
        int          nack;
        bit          done;
        logic [1:0]  exp_oh;
        logic        f_we[2];
        logic [1:0]  f_bg[2];
        logic [5:0]  f_addr[2];
        logic [15:0] f_wd[2];

        rst_n       = 1'b0;
        req_valid   = 2'b00;
        req_we      = 2'b00;
        req_bg      = 4'h0;
        req_nib     = 2'b00;
        req_addr    = 12'h000;
        req_wdata   = 32'h0;
        riu_valid_i = 4'hF;
        for (int i = 0; i < 4; i++) rdv[i] = 16'h0000;

        // Reset state.
        #1;
        chk("rst_ack",    32'(req_ack),     32'h0);
        chk("rst_rsp",    32'(rsp_valid),   32'h0);
        chk("rst_rdata",  32'(rsp_rdata),   32'h0);
        chk("rst_err",    32'(rsp_err),     32'h0);
        chk("rst_addr",   32'(riu_addr),    32'h0);
        chk("rst_nib",    32'(riu_nib_sel), 32'h0);
        chk("rst_wdata",  32'(riu_wr_data), 32'h0);
        chk("rst_wren",   32'(riu_wr_en),   32'h0);
        chk("rst_busy",   32'(busy),        32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{0, 1'b0, 2'd2, 1'b1, 6'h15, 16'h0000, 16'hA5A5, 2'b01, 2'b10, 1 + RD_LAT, 4'b0000, 16'hA5A5};
        vecs[1] = '{1, 1'b1, 2'd3, 1'b0, 6'h02, 16'h1234, 16'h5555, 2'b10, 2'b01, 1,          4'b1000, 16'h0000};
        vecs[2] = '{1, 1'b0, 2'd0, 1'b0, 6'h3F, 16'h0000, 16'h0001, 2'b10, 2'b01, 1 + RD_LAT, 4'b0000, 16'h0001};
        vecs[3] = '{0, 1'b1, 2'd1, 1'b1, 6'h00, 16'hFFFF, 16'h7777, 2'b01, 2'b10, 1,          4'b0010, 16'h0000};
        vecs[4] = '{0, 1'b0, 2'd3, 1'b0, 6'h2A, 16'h0000, 16'h8001, 2'b01, 2'b01, 1 + RD_LAT, 4'b0000, 16'h8001};
        vecs[5] = '{1, 1'b1, 2'd0, 1'b1, 6'h11, 16'hBEEF, 16'h4242, 2'b10, 2'b10, 1,          4'b0001, 16'h0000};

        foreach (vecs[v]) begin
            for (int b = 0; b < 4; b++) rdv[b] = ~vecs[v].rd;
            rdv[vecs[v].bg] = vecs[v].rd;
            set_req(vecs[v].r, vecs[v].we, vecs[v].bg, vecs[v].nib, vecs[v].addr, vecs[v].wd);
            do_txn(vecs[v].r);
            chk($sformatf("v%0d_to", v),      32'(o_to),      32'h0);
            chk($sformatf("v%0d_ack", v),     32'(o_ack),     32'(vecs[v].e_ack));
            chk($sformatf("v%0d_nib", v),     32'(o_nib),     32'(vecs[v].e_nib));
            chk($sformatf("v%0d_nibcnt", v),  32'(o_nib_cnt), 32'(vecs[v].e_nib_cnt));
            chk($sformatf("v%0d_wren", v),    32'(o_wren),    32'(vecs[v].e_wren));
            chk($sformatf("v%0d_wdata", v),   32'(o_wdata),   32'(vecs[v].we ? vecs[v].wd : 16'h0000));
            chk($sformatf("v%0d_rsp", v),     32'(o_rsp),     32'(vecs[v].e_ack));
            chk($sformatf("v%0d_rdata", v),   32'(o_rdata),   32'(vecs[v].e_rdata));
            chk($sformatf("v%0d_err", v),     32'(o_err),     32'h0);
            chk($sformatf("v%0d_addr", v),    32'(o_addr),    32'(vecs[v].addr));
        end

        // Valid timeout on bg1, then a normal read of the same group.
        riu_valid_i = 4'b1101;
        set_req(0, 1'b0, 2'd1, 1'b0, 6'h07, 16'h0000);
        do_txn(0);
        chk("tmo_to",    32'(o_to),    32'h0);
        chk("tmo_rsp",   32'(o_rsp),   32'h1);
        chk("tmo_err",   32'(o_err),   32'h1);
        chk("tmo_rdata", 32'(o_rdata), 32'h0);
        chk("tmo_lat",   32'(o_lat),   32'(VALID_TMO));
        chk("tmo_nib",   32'(o_nib_cnt), 32'h0);
        riu_valid_i = 4'hF;
        rdv[1] = 16'h0F0F;
        do_txn(0);
        chk("post_tmo_err",   32'(o_err),   32'h0);
        chk("post_tmo_rdata", 32'(o_rdata), 32'h0F0F);

        // Reset while the read is waiting on data.
        rdv[1] = 16'h3C3C;
        set_req(0, 1'b0, 2'd1, 1'b0, 6'h09, 16'h0000);
        @(negedge clk);
        req_valid[0] = 1'b1;
        nibcnt = 0;
        for (int c = 0; c < 50 && nibcnt < 2; c++) begin
            @(negedge clk);
            if (req_ack != 2'b00) req_valid[0] = 1'b0;
            if (riu_nib_sel != 2'b00) nibcnt++;
        end
        chk("mid_reached_rdwait", 32'(nibcnt), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_nib",  32'(riu_nib_sel), 32'h0);
        chk("mid_busy", 32'(busy),        32'h0);
        chk("mid_addr", 32'(riu_addr),    32'h0);
        chk("mid_rsp",  32'(rsp_valid),   32'h0);
        nack = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) nack++;
        end
        chk("mid_no_rsp", 32'(nack), 32'h0);
        rst_n = 1'b1;
        do_txn(0);
        chk("mid_after_rsp",   32'(o_rsp),   32'h1);
        chk("mid_after_rdata", 32'(o_rdata), 32'h3C3C);

        // Contention right after reset: grants alternate starting at 0.
        do_reset();
        set_req(0, 1'b0, 2'd0, 1'b0, 6'h01, 16'h0000);
        set_req(1, 1'b1, 2'd1, 1'b1, 6'h02, 16'hCAFE);
        req_valid = 2'b11;
        nack = 0;
        for (int c = 0; c < 200 && nack < 4; c++) begin
            @(negedge clk);
            if (req_ack != 2'b00) begin
                got[nack] = req_ack[1] ? 1 : 0;
                nack++;
            end
        end
        req_valid = 2'b00;
        chk("cont_nack", 32'(nack), 32'h4);
        for (int k = 0; k < 4; k++) chk($sformatf("cont_g%0d", k), 32'(got[k]), 32'(k % 2));
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        @(negedge clk);

        // Randomized traffic checked against a round-robin transaction model.
        do_reset();
        mptr = 1'b0;
        for (int it = 0; it < 30; it++) begin
            pend = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                f_we[r]   = 1'($urandom);
                f_bg[r]   = 2'($urandom);
                f_addr[r] = 6'($urandom);
                f_wd[r]   = 16'($urandom);
                set_req(r, f_we[r], f_bg[r], 1'($urandom), f_addr[r], f_wd[r]);
            end
            for (int b = 0; b < 4; b++) rdv[b] = 16'($urandom);
            req_valid = pend;
            cur = 0;
            nibcnt = 0;
            done = 1'b0;
            for (int c = 0; c < 2000 && !done; c++) begin
                @(negedge clk);
                if (req_ack != 2'b00) begin
                    cur = (pend == 2'b11) ? int'(mptr) : int'(pend[1]);
                    exp_oh = (cur == 1) ? 2'b10 : 2'b01;
                    chk("rnd_ack", 32'(req_ack), 32'(exp_oh));
                    mptr = (cur == 0);
                    pend[cur] = 1'b0;
                    req_valid[cur] = 1'b0;
                    nibcnt = 0;
                end
                if (riu_nib_sel != 2'b00) nibcnt++;
                if (riu_wr_en != 4'b0000) begin
                    chk("rnd_wren", 32'(riu_wr_en), f_we[cur] ? (32'd1 << f_bg[cur]) : 32'd0);
                    chk("rnd_wdata", 32'(riu_wr_data), 32'(f_wd[cur]));
                end
                if (rsp_valid != 2'b00) begin
                    exp_oh = (cur == 1) ? 2'b10 : 2'b01;
                    chk("rnd_rsp",    32'(rsp_valid), 32'(exp_oh));
                    chk("rnd_err",    32'(rsp_err),   32'h0);
                    chk("rnd_rdata",  32'(rsp_rdata), f_we[cur] ? 32'h0 : 32'(rdv[f_bg[cur]]));
                    chk("rnd_nibcnt", 32'(nibcnt),    32'(f_we[cur] ? 1 : 1 + RD_LAT));
                    chk("rnd_addr",   32'(riu_addr),  32'(f_addr[cur]));
                    if (pend == 2'b00) done = 1'b1;
                end
                riu_valid_i = 4'($urandom);
            end
            chk("rnd_complete", 32'(done), 32'h1);
            riu_valid_i = 4'hF;
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
